// File: rtl/keccak_arbiter.sv
// Two-requester arbiter in front of a single keccak core: IDLE/BUSY/GAP FSM, registered grant.
// Define KECCAK_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module keccak_arbiter #(
  parameter int unsigned GAP_CYC = 1
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [1:0]    i_rq_req,
  input  logic [3:0]    i_rq_mode,
  input  logic [21:0]   i_rq_ibytes_len,
  input  logic [19:0]   i_rq_obytes_len,
  input  logic [127:0]  i_rq_ibytes,
  input  logic [1:0]    i_rq_ibytes_valid,
  output logic [1:0]    o_rq_ibytes_ready,
  output logic [63:0]   o_rq_obytes,
  output logic [1:0]    o_rq_obytes_valid,
  output logic [1:0]    o_rq_done,
  output logic [1:0]    o_gnt,
  output logic [1:0]    o_k_mode,
  output logic [10:0]   o_k_ibytes_len,
  output logic [9:0]    o_k_obytes_len,
  output logic [63:0]   o_k_ibytes,
  output logic          o_k_ibytes_valid,
  input  logic          i_k_ibytes_ready,
  input  logic [63:0]   i_k_obytes,
  input  logic          i_k_obytes_valid,
  input  logic          i_k_obytes_done
);

  typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t     state, state_nxt;
  logic [1:0] gnt_nxt;
  logic [1:0] done_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic       done_q;
  logic [1:0] win;
  logic       busy;
  logic       sel;

`ifdef KECCAK_ARB_RR_EN
  logic ptr, ptr_nxt;

  // ptr names the requester preferred on a tie
  always_comb begin
    win = '0;
    if (i_rq_req[ptr])       win[ptr]  = 1'b1;
    else if (i_rq_req[~ptr]) win[~ptr] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) ptr <= 1'b0;
    else         ptr <= ptr_nxt;
  end
`else
  always_comb begin
    win = '0;
    if (i_rq_req[0])      win = 2'b01;
    else if (i_rq_req[1]) win = 2'b10;
  end
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = o_gnt;
    done_nxt    = '0;
    gap_cnt_nxt = gap_cnt;
`ifdef KECCAK_ARB_RR_EN
    ptr_nxt     = ptr;
`endif
    case (state)
      IDLE: begin
        if (|i_rq_req) begin
          state_nxt = BUSY;
          gnt_nxt   = win;
`ifdef KECCAK_ARB_RR_EN
          ptr_nxt   = win[0];
`endif
        end
      end
      BUSY: begin
        // job ends on the falling edge of the core's done level
        if (done_q && !i_k_obytes_done) begin
          state_nxt   = GAP;
          gnt_nxt     = '0;
          done_nxt    = o_gnt;
          gap_cnt_nxt = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = gap_cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      o_gnt     <= '0;
      o_rq_done <= '0;
      gap_cnt   <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      o_gnt     <= gnt_nxt;
      o_rq_done <= done_nxt;
      gap_cnt   <= gap_cnt_nxt;
      done_q    <= (state == BUSY) && i_k_obytes_done;
    end
  end

  assign busy = (state == BUSY);
  assign sel  = o_gnt[1];

  always_comb begin
    o_k_mode          = '0;
    o_k_ibytes_len    = '0;
    o_k_obytes_len    = '0;
    o_k_ibytes        = '0;
    o_k_ibytes_valid  = 1'b0;
    o_rq_obytes       = '0;
    o_rq_ibytes_ready = '0;
    o_rq_obytes_valid = '0;
    if (busy) begin
      if (sel) begin
        o_k_mode         = i_rq_mode[3:2];
        o_k_ibytes_len   = i_rq_ibytes_len[21:11];
        o_k_obytes_len   = i_rq_obytes_len[19:10];
        o_k_ibytes       = i_rq_ibytes[127:64];
        o_k_ibytes_valid = i_rq_ibytes_valid[1];
      end else begin
        o_k_mode         = i_rq_mode[1:0];
        o_k_ibytes_len   = i_rq_ibytes_len[10:0];
        o_k_obytes_len   = i_rq_obytes_len[9:0];
        o_k_ibytes       = i_rq_ibytes[63:0];
        o_k_ibytes_valid = i_rq_ibytes_valid[0];
      end
      o_rq_obytes       = i_k_obytes;
      o_rq_ibytes_ready = o_gnt & {2{i_k_ibytes_ready}};
      o_rq_obytes_valid = o_gnt & {2{i_k_obytes_valid}};
    end
  end

endmodule

// File: tb/tb_keccak_arbiter.sv
// Directed + randomized bench for keccak_arbiter; the bench plays the keccak core.
// Expected owners come from a reference arbitration model (fixed priority or round-robin).
module tb_keccak_arbiter;

  localparam int GAP = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [1:0]    req;
  logic [3:0]    mode;
  logic [21:0]   ilen;
  logic [19:0]   olen;
  logic [127:0]  ibytes;
  logic [1:0]    ivalid;
  logic [1:0]    rq_ready;
  logic [63:0]   rq_obytes;
  logic [1:0]    rq_ovalid;
  logic [1:0]    rq_done;
  logic [1:0]    gnt;
  logic [1:0]    k_mode;
  logic [10:0]   k_ilen;
  logic [9:0]    k_olen;
  logic [63:0]   k_ibytes;
  logic          k_ivalid;
  logic          k_iready;
  logic [63:0]   k_obytes;
  logic          k_ovalid;
  logic          k_done;

  int n_assert = 0;
  int n_fail   = 0;
  int rr_ptr   = 0;

  always #5 clk = ~clk;

  keccak_arbiter #(.GAP_CYC(GAP)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_rq_req(req), .i_rq_mode(mode), .i_rq_ibytes_len(ilen), .i_rq_obytes_len(olen),
    .i_rq_ibytes(ibytes), .i_rq_ibytes_valid(ivalid), .o_rq_ibytes_ready(rq_ready),
    .o_rq_obytes(rq_obytes), .o_rq_obytes_valid(rq_ovalid), .o_rq_done(rq_done), .o_gnt(gnt),
    .o_k_mode(k_mode), .o_k_ibytes_len(k_ilen), .o_k_obytes_len(k_olen), .o_k_ibytes(k_ibytes),
    .o_k_ibytes_valid(k_ivalid), .i_k_ibytes_ready(k_iready), .i_k_obytes(k_obytes),
    .i_k_obytes_valid(k_ovalid), .i_k_obytes_done(k_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Reference arbitration: who wins from request vector r with preference pointer p
  function automatic int pick(input logic [1:0] r, input int p);
`ifdef KECCAK_ARB_RR_EN
    if (r[p]) return p;
    return 1 - p;
`else
    if (r[0]) return 0;
    return 1;
`endif
  endfunction

  task automatic grant_model(input logic [1:0] r, output int own);
    own    = pick(r, rr_ptr);
    rr_ptr = (own + 1) % 2;
  endtask

  task automatic rand_fields();
    mode = 4'($urandom);
    ilen = {11'($urandom_range(1, 40)), 11'($urandom_range(1, 40))};
    olen = {10'($urandom_range(1, 32)), 10'($urandom_range(1, 32))};
  endtask

  task automatic rand_data();
    ibytes   = {$urandom, $urandom, $urandom, $urandom};
    ivalid   = 2'($urandom);
    k_obytes = {$urandom, $urandom};
  endtask

  task automatic chk_quiet(input logic [1:0] exp_done);
    chk("idle_gnt", 64'(gnt), 0);
    chk("idle_done", 64'(rq_done), 64'(exp_done));
    chk("idle_k_ivalid", 64'(k_ivalid), 0);
    chk("idle_k_mode", 64'(k_mode), 0);
    chk("idle_k_ilen", 64'(k_ilen), 0);
    chk("idle_k_olen", 64'(k_olen), 0);
    chk("idle_k_ibytes", k_ibytes, 0);
    chk("idle_rq_ready", 64'(rq_ready), 0);
    chk("idle_rq_obytes", rq_obytes, 0);
    chk("idle_rq_ovalid", 64'(rq_ovalid), 0);
  endtask

  task automatic chk_busy(input int own);
    logic [1:0] oh;
    oh = 2'(1 << own);
    chk("gnt", 64'(gnt), 64'(oh));
    chk("busy_done", 64'(rq_done), 0);
    chk("k_mode", 64'(k_mode), 64'(mode[2*own +: 2]));
    chk("k_ilen", 64'(k_ilen), 64'(ilen[11*own +: 11]));
    chk("k_olen", 64'(k_olen), 64'(olen[10*own +: 10]));
    chk("k_ibytes", k_ibytes, ibytes[64*own +: 64]);
    chk("k_ivalid", 64'(k_ivalid), 64'(ivalid[own]));
    chk("rq_ready", 64'(rq_ready), k_iready ? 64'(oh) : 64'd0);
    chk("rq_obytes", rq_obytes, k_obytes);
    chk("rq_ovalid", 64'(rq_ovalid), k_ovalid ? 64'(oh) : 64'd0);
  endtask

  // Entered right after the grant edge; leaves in the following IDLE cycle with req = next_req.
  task automatic run_job(input int own, input int drop_at, input logic [1:0] next_req);
    int nin, nout, c;
    nin  = (int'(ilen[11*own +: 11]) + 7) / 8;
    nout = (int'(olen[10*own +: 10]) + 7) / 8;
    c    = 0;
    k_iready = 1'b1;
    k_ovalid = 1'b0;
    for (int i = 0; i < nin; i++) begin
      rand_data();
      ivalid[own] = 1'b1;
      if (c == drop_at) req[own] = 1'b0;
      settle(); chk_busy(own); step(); c++;
    end
    k_iready = 1'b0;
    for (int i = 0; i < nout; i++) begin
      rand_data();
      k_ovalid = 1'b1;
      if (c == drop_at) req[own] = 1'b0;
      settle(); chk_busy(own); step(); c++;
    end
    k_ovalid = 1'b0;
    k_done   = 1'b1;
    settle(); chk_busy(own); step();
    k_done   = 1'b0;
    settle(); chk_busy(own); step();
    // GAP: outputs gated regardless of core/requester activity, requests ignored
    for (int g = 0; g < GAP; g++) begin
      rand_data();
      req      = 2'($urandom);
      k_iready = 1'b1;
      k_ovalid = 1'b1;
      settle();
      chk_quiet(g == 0 ? 2'(1 << own) : 2'b00);
      step();
    end
    req      = next_req;
    k_iready = 1'b0;
    k_ovalid = 1'b0;
    settle();
    chk_quiet(2'b00);
  endtask

  initial begin
    int own;
    logic [1:0] cur, nxt;

    // reset state with busy-looking inputs
    rstn = 1'b0; req = 2'b11; rand_fields(); rand_data();
    k_iready = 1'b1; k_ovalid = 1'b1; k_done = 1'b0;
    #12;
    chk_quiet(2'b00);
    step();
    req = '0; k_iready = 1'b0; k_ovalid = 1'b0;
    rstn = 1'b1; rr_ptr = 0;
    settle(); chk_quiet(2'b00);

    // single request: 34 input bytes (5 words), 32 output bytes (4 words); requester 1 idle but valid
    mode = 4'b1100; ilen = {11'd17, 11'd34}; olen = {10'd9, 10'd32};
    req = 2'b01;
    step();
    grant_model(2'b01, own);
    run_job(own, -1, 2'b00);
    step(); settle(); chk_quiet(2'b00);

    // simultaneous requests held from a fresh reset
    rstn = 1'b0; settle(); chk_quiet(2'b00);
    step(); rstn = 1'b1; rr_ptr = 0;
    mode = 4'($urandom); ilen = {11'd8, 11'd8}; olen = {10'd8, 10'd16};
    req = 2'b11;
    for (int j = 0; j < 3; j++) begin
      step();
      grant_model(2'b11, own);
      run_job(own, -1, j == 2 ? 2'b00 : 2'b11);
    end

    // withdrawal two cycles into BUSY
    rand_fields();
    ilen = {11'd24, 11'd24};
    req = 2'b01;
    step();
    grant_model(2'b01, own);
    run_job(own, 2, 2'b00);
    step(); settle(); chk_quiet(2'b00);

    // randomized job stream
    cur = 2'($urandom_range(1, 3));
    req = cur;
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      step();
      grant_model(cur, own);
      nxt = (k == 7) ? 2'b00 : 2'($urandom_range(1, 3));
      run_job(own, -1, nxt);
      cur = nxt;
    end

    // reset during output phase
    rand_fields();
    req = 2'b10;
    step();
    grant_model(2'b10, own);
    rand_data(); k_iready = 1'b1;
    settle(); chk_busy(own); step();
    rand_data(); k_iready = 1'b0; k_ovalid = 1'b1; k_done = 1'b1;
    settle(); chk_busy(own);
    rstn = 1'b0;
    #1;
    chk_quiet(2'b00);
    step();
    rstn = 1'b1; rr_ptr = 0; req = '0; k_done = 1'b0; k_ovalid = 1'b0;
    settle(); chk_quiet(2'b00);
    step(); settle(); chk_quiet(2'b00);
    rand_fields();
    req = 2'b11;
    step();
    grant_model(2'b11, own);
    run_job(own, -1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
